// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: predicts next PC at fetch, resolves
// control flow in execute, updates the table on the following edge and counts outcomes.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [XLEN-1:0]  f_pc,
  output logic             f_pred_taken,
  output logic [XLEN-1:0]  f_pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_cond,
  input  logic             ex_is_uncond,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stat_ctl,
  output logic [CNT_W-1:0] stat_miss
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  // A zero-width tag is stored as one constant bit so every PC of an index matches.
  localparam int TW    = (TAG_W > 0) ? TAG_W : 1;

  function automatic logic [TW-1:0] pc_tag(input logic [XLEN-1:0] pc);
    logic [XLEN-1:0] sh;
    sh = pc >> IDX_W;
    if (TAG_W == 0) pc_tag = '0;
    else            pc_tag = sh[TW-1:0];
  endfunction

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    ctr_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    ctr_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic            valid_r  [ENTRIES];
  logic [TW-1:0]   tag_r    [ENTRIES];
  logic [XLEN-1:0] target_r [ENTRIES];
  logic [1:0]      ctr_r    [ENTRIES];
  logic [CNT_W-1:0] stat_ctl_r;
  logic [CNT_W-1:0] stat_miss_r;

  logic [IDX_W-1:0] f_idx_s;
  logic [IDX_W-1:0] ex_idx_s;
  logic [TW-1:0]    ex_tag_s;
  logic             f_hit_s;
  logic             ex_hit_s;
  logic             is_ctl_s;
  logic             act_taken_s;
  logic [XLEN-1:0]  act_next_s;
  logic             mispredict_s;

  assign f_idx_s  = f_pc[IDX_W-1:0];
  assign ex_idx_s = ex_pc[IDX_W-1:0];
  assign ex_tag_s = pc_tag(ex_pc);
  assign f_hit_s  = valid_r[f_idx_s] && (tag_r[f_idx_s] == pc_tag(f_pc));
  assign ex_hit_s = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);

  assign f_pred_taken  = f_hit_s & ctr_r[f_idx_s][1];
  assign f_pred_target = f_pred_taken ? target_r[f_idx_s] : f_pc + XLEN'(1);

  // Carried prediction direction is implied by the carried target; only the target is compared.
  assign is_ctl_s     = ex_is_cond | ex_is_uncond;
  assign act_taken_s  = ex_is_uncond | (ex_is_cond & ex_taken);
  assign act_next_s   = act_taken_s ? ex_target : ex_pc + XLEN'(1);
  assign mispredict_s = ex_valid & (ex_pred_target != act_next_s);
  assign mispredict   = mispredict_s;
  assign redirect_pc  = act_next_s;
  assign stat_ctl     = stat_ctl_r;
  assign stat_miss    = stat_miss_r;

  // BTB entry update from the resolved execute instruction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= '0;
        ctr_r[i]    <= 2'b00;
      end
    end else if (ex_valid) begin
      if (act_taken_s) begin
        valid_r[ex_idx_s]  <= 1'b1;
        tag_r[ex_idx_s]    <= ex_tag_s;
        target_r[ex_idx_s] <= ex_target;
        if (ex_hit_s)          ctr_r[ex_idx_s] <= ctr_inc(ctr_r[ex_idx_s]);
        else if (ex_is_uncond) ctr_r[ex_idx_s] <= 2'b11;
        else                   ctr_r[ex_idx_s] <= 2'b10;
      end else if (ex_is_cond) begin
        if (ex_hit_s) ctr_r[ex_idx_s] <= ctr_dec(ctr_r[ex_idx_s]);
      end else if (ex_hit_s) begin
        valid_r[ex_idx_s] <= 1'b0;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_ctl_r  <= '0;
      stat_miss_r <= '0;
    end else begin
      if (ex_valid && is_ctl_s && (stat_ctl_r != {CNT_W{1'b1}}))
        stat_ctl_r <= stat_ctl_r + CNT_W'(1);
      if (mispredict_s && (stat_miss_r != {CNT_W{1'b1}}))
        stat_miss_r <= stat_miss_r + CNT_W'(1);
    end
  end

endmodule
